// File: rtl/posit_ppu_pkg.sv
// Shared types and constants for the posit processing unit slice.
// Used by the square-root sequencing controller and its testbench.
package posit_ppu_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;

  localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

  localparam int FLAG_W       = 3;
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_INVALID = 1;
  localparam int FLAG_TIMEOUT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXTRACT,
    ST_SQRT,
    ST_ROUND,
    ST_RESULT
  } sqrt_ctrl_state_e;

endpackage

// File: rtl/posit_wait_timer.sv
// Saturating wait counter: clear has priority, enable counts, expired flags
// the final permitted wait cycle (count == MAX_WAIT-1).
module posit_wait_timer #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/posit_sqrt_ctrl.sv
// Sequencing controller for extraction -> sqrt -> rounding, with zero/NaR/negative
// short-circuits, per-stage timeout and valid/ready operand and result handshakes.
module posit_sqrt_ctrl
  import posit_ppu_pkg::*;
#(
  parameter int N        = POSIT_N,
  parameter int ES       = POSIT_ES,
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N-1:0]      in_operand_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  input  logic              flush_i,
  output logic [N-1:0]      ext_operand_o,
  input  logic              ext_sign_i,
  input  logic              ext_zero_i,
  input  logic              ext_nar_i,
  output logic              sqrt_en_o,
  input  logic              sqrt_done_i,
  input  logic              sqrt_nar_i,
  output logic              rnd_en_o,
  input  logic              rnd_done_i,
  input  logic [N-1:0]      rnd_result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N-1:0]      out_result_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [FLAG_W-1:0] out_flags_o,
  output logic              busy_o
);

  localparam logic [N-1:0] NAR_VAL  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ZERO_VAL = '0;

  if (N < 3 || ES < 0 || ES > N - 3 || MAX_WAIT < 2) begin : g_bad_cfg
    $error("posit_sqrt_ctrl: unsupported parameter set");
  end

  sqrt_ctrl_state_e    state_q, state_d;
  logic [N-1:0]        operand_q, result_q, res_d;
  logic [TAG_W-1:0]    tag_q;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                load_op, load_res;
  logic                timer_clear, timer_expired;

  posit_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  ((state_q == ST_SQRT) || (state_q == ST_ROUND)),
    .expired_o (timer_expired)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    load_op     = 1'b0;
    load_res    = 1'b0;
    res_d       = NAR_VAL;
    flags_d     = '0;
    timer_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          load_op = 1'b1;
          state_d = ST_EXTRACT;
        end
      end
      ST_EXTRACT: begin
        if (ext_zero_i) begin
          load_res           = 1'b1;
          res_d              = ZERO_VAL;
          flags_d[FLAG_ZERO] = 1'b1;
          state_d            = ST_RESULT;
        end else if (ext_nar_i || ext_sign_i) begin
          load_res              = 1'b1;
          flags_d[FLAG_INVALID] = 1'b1;
          state_d               = ST_RESULT;
        end else begin
          timer_clear = 1'b1;
          state_d     = ST_SQRT;
        end
      end
      ST_SQRT: begin
        // Done takes priority over a simultaneous expiry.
        if (sqrt_done_i) begin
          if (sqrt_nar_i) begin
            load_res              = 1'b1;
            flags_d[FLAG_INVALID] = 1'b1;
            state_d               = ST_RESULT;
          end else begin
            timer_clear = 1'b1;
            state_d     = ST_ROUND;
          end
        end else if (timer_expired) begin
          load_res              = 1'b1;
          flags_d[FLAG_TIMEOUT] = 1'b1;
          state_d               = ST_RESULT;
        end
      end
      ST_ROUND: begin
        if (rnd_done_i) begin
          load_res           = 1'b1;
          res_d              = rnd_result_i;
          flags_d[FLAG_ZERO] = (rnd_result_i == ZERO_VAL);
          state_d            = ST_RESULT;
        end else if (timer_expired) begin
          load_res              = 1'b1;
          flags_d[FLAG_TIMEOUT] = 1'b1;
          state_d               = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a pending accept or result capture.
    if (flush_i) begin
      state_d  = ST_IDLE;
      load_op  = 1'b0;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_op) begin
        operand_q <= in_operand_i;
        tag_q     <= in_tag_i;
      end
      if (load_res) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign in_ready_o    = (state_q == ST_IDLE) && !flush_i;
  assign ext_operand_o = operand_q;
  assign sqrt_en_o     = (state_q == ST_SQRT);
  assign rnd_en_o      = (state_q == ST_ROUND);
  assign out_valid_o   = (state_q == ST_RESULT);
  assign out_result_o  = result_q;
  assign out_tag_o     = tag_q;
  assign out_flags_o   = flags_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_posit_sqrt_ctrl.sv
// Scoreboard bench for posit_sqrt_ctrl: directed operands push expected results,
// a negedge monitor compares every valid output cycle against the queue head.
module tb_posit_sqrt_ctrl;
  import posit_ppu_pkg::*;

  localparam int N        = 32;
  localparam int TAG_W    = 4;
  localparam int MAX_WAIT = 64;

  typedef struct {
    logic [N-1:0]     res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, flush, out_ready;
  logic [N-1:0]     in_operand;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready_o, sqrt_en_o, rnd_en_o, out_valid_o, busy_o;
  logic [N-1:0]     ext_operand_o, out_result_o;
  logic [TAG_W-1:0] out_tag_o;
  logic [2:0]       out_flags_o;

  logic             sqrt_mode, rnd_mode;
  logic [N-1:0]     rnd_value;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   sqrt_cnt = 0;
  int   rnd_cnt  = 0;

  // Stage stubs: extraction decodes the registered operand, sqrt/rounding answer in-cycle.
  wire ext_zero = (ext_operand_o == POSIT_ZERO);
  wire ext_nar  = (ext_operand_o == POSIT_NAR);
  wire ext_sign = ext_operand_o[N-1];
  wire sqrt_done = sqrt_en_o && sqrt_mode;
  wire rnd_done  = rnd_en_o && rnd_mode;

  posit_sqrt_ctrl #(.N(N), .ES(2), .TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready_o),
    .in_operand_i  (in_operand),
    .in_tag_i      (in_tag),
    .flush_i       (flush),
    .ext_operand_o (ext_operand_o),
    .ext_sign_i    (ext_sign),
    .ext_zero_i    (ext_zero),
    .ext_nar_i     (ext_nar),
    .sqrt_en_o     (sqrt_en_o),
    .sqrt_done_i   (sqrt_done),
    .sqrt_nar_i    (1'b0),
    .rnd_en_o      (rnd_en_o),
    .rnd_done_i    (rnd_done),
    .rnd_result_i  (rnd_value),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result_o),
    .out_tag_o     (out_tag_o),
    .out_flags_o   (out_flags_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: enable activity counters plus scoreboard comparison on every valid cycle.
  initial begin
    bit seen_first = 1'b0;
    forever begin
      @(negedge clk);
      if (sqrt_en_o) sqrt_cnt++;
      if (rnd_en_o)  rnd_cnt++;
      if (rst_n && out_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out actual=%0h required=none (cycle %0d)", out_result_o, cyc);
        end else begin
          if (!seen_first) begin
            seen_first = 1'b1;
            check("out_latency", 64'(cyc), 64'(sb[0].cyc));
          end
          check("out_result", 64'(out_result_o), 64'(sb[0].res));
          check("out_tag",    64'(out_tag_o),    64'(sb[0].tag));
          check("out_flags",  64'(out_flags_o),  64'(sb[0].flags));
          check("busy_in_result", 64'(busy_o), 64'd1);
          if (out_ready) begin
            void'(sb.pop_front());
            seen_first = 1'b0;
          end
        end
      end
    end
  end

  // Presents one operand; acc is the cycle whose closing edge performs the accept.
  task automatic send(input logic [N-1:0] op, input logic [TAG_W-1:0] tag, input int lat,
                      input logic [N-1:0] er, input logic [2:0] ef, input bit expect_out,
                      output int acc);
    exp_t e;
    in_valid   = 1'b1;
    in_operand = op;
    in_tag     = tag;
    acc        = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout actual=no_ready required=ready (cycle %0d)", cyc);
    end else if (expect_out) begin
      e.res = er; e.tag = tag; e.flags = ef; e.cyc = acc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid_o) break;
    end
    if (i == 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d required=0 (cycle %0d)", sb.size(), cyc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, s0, r0, p;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_operand = '0; in_tag = '0;
    sqrt_mode = 1'b1; rnd_mode = 1'b1; rnd_value = 32'h5A5A0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_enables",   64'({sqrt_en_o, rnd_en_o}), 64'd0);
    check("rst_regs",      64'({out_result_o, out_flags_o, out_tag_o}), 64'd0);
    check("rst_ext_op",    64'(ext_operand_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: zero short-circuit
    send(32'h00000000, 4'd3, 2, 32'h00000000, 3'b001, 1'b1, acc);
    drain();

    // 2: NaR and negative operands, no sqrt activity
    s0 = sqrt_cnt;
    send(32'h80000000, 4'd7, 2, 32'h80000000, 3'b010, 1'b1, acc);
    drain();
    send(32'hC0000000, 4'd9, 2, 32'h80000000, 3'b010, 1'b1, acc);
    drain();
    check("neg_no_sqrt_en", 64'(sqrt_cnt - s0), 64'd0);

    // 3: full path, same-cycle Done
    s0 = sqrt_cnt; r0 = rnd_cnt;
    send(32'h6B31C72A, 4'd5, 4, 32'h5A5A0000, 3'b000, 1'b1, acc);
    drain();
    check("full_sqrt_en_cycles", 64'(sqrt_cnt - s0), 64'd1);
    check("full_rnd_en_cycles",  64'(rnd_cnt - r0),  64'd1);

    // 4: sqrt timeout
    sqrt_mode = 1'b0;
    s0 = sqrt_cnt; r0 = rnd_cnt;
    send(32'h6B31C72A, 4'd10, MAX_WAIT + 2, 32'h80000000, 3'b100, 1'b1, acc);
    drain();
    check("tmo_sqrt_en_cycles", 64'(sqrt_cnt - s0), 64'(MAX_WAIT));
    check("tmo_no_rnd_en",      64'(rnd_cnt - r0),  64'd0);

    // 5: flush on the third SQRT cycle
    send(32'h6B31C72A, 4'd12, 0, 32'h0, 3'b000, 1'b0, acc);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_sqrt",  64'(sqrt_en_o),  64'd1);
    check("flush_in_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy",  64'(busy_o),      64'd0);
    check("flush_sqrt_en",    64'(sqrt_en_o),   64'd0);
    check("flush_out_valid",  64'(out_valid_o), 64'd0);
    check("flush_ready_back", 64'(in_ready_o),  64'd1);
    @(posedge clk); #1;
    sqrt_mode = 1'b1;
    rnd_value = 32'h00000000;
    send(32'h40000000, 4'd13, 4, 32'h00000000, 3'b001, 1'b1, acc);
    drain();

    // 6: output backpressure, then back-to-back accept
    out_ready = 1'b0;
    send(32'h00000000, 4'd6, 2, 32'h00000000, 3'b001, 1'b1, acc);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held",  64'(out_valid_o), 64'd1);
      check("bp_in_ready_lo", 64'(in_ready_o),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    p = cyc;
    rnd_value = 32'h3C000000;
    send(32'h50000000, 4'd14, 4, 32'h3C000000, 3'b000, 1'b1, acc);
    check("b2b_accept_cycle", 64'(acc), 64'(p + 1));
    drain();

    // Reset mid-operation discards the operand
    sqrt_mode = 1'b0;
    send(32'h6B31C72A, 4'd1, 0, 32'h0, 3'b000, 1'b0, acc);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sqrt_mode = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy_o), 64'd0);
    repeat (10) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
